round_ack_responder: RTL and testbench

// Counterpart of the round-timer FSM: consumes its finish/reset outputs and drives its bCen input.

---
 rtl/round_ack_responder.sv | 252 +++++++++++++++++++++++++
 tb/tb_round_ack_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_ack_responder.sv
// -----------------------------------------------------------------------------
// round_ack_responder
//
// Counterpart of the round-timer FSM. It debounces the raw centre button,
// keeps the round score and the best score, and converts each physical press
// into exactly one single-cycle acknowledge pulse (wired to the timer bCen
// input). After every acknowledge it waits for the timer to confirm by
// changing its reset/finish levels before another acknowledge is allowed, so
// a held button can never step the timer through two states.
//
// Ports
//   clk          in   1        system clock, all logic on posedge
//   rst_n        in   1        asynchronous active-low reset
//   finish_i     in   1        timer "round over" level
//   reset_i      in   1        timer "reset phase" level
//   btn_center_i in   1        raw asynchronous centre button, active-high
//   hit_i        in   1        one-cycle score event
//   ack_o        out  1        one-cycle acknowledge pulse (timer bCen)
//   score_o      out  SCORE_W  current round score
//   best_o       out  SCORE_W  best score since reset
//   disp_mode_o  out  2        00 play, 01 game over, 10 ready
//   err_o        out  1        sticky: timer did not confirm an acknowledge
// -----------------------------------------------------------------------------
module round_ack_responder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCORE_W         = 8,
    parameter int ACK_TIMEOUT     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               finish_i,
    input  logic               reset_i,
    input  logic               btn_center_i,
    input  logic               hit_i,
    output logic               ack_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] best_o,
    output logic [1:0]         disp_mode_o,
    output logic               err_o
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        ST_PLAY   = 3'd0,
        ST_OVER   = 3'd1,
        ST_ACK1   = 3'd2,
        ST_WAIT_R = 3'd3,
        ST_READY  = 3'd4,
        ST_ACK2   = 3'd5,
        ST_WAIT_P = 3'd6
    } state_e;

    // Saturating increment: the score sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + SCORE_W'(1);
        end
        return r;
    endfunction

    // Display mode belonging to a state; ACK/WAIT states show the phase they came from.
    function automatic logic [1:0] disp_of(input state_e s);
        logic [1:0] m;
        case (s)
            ST_PLAY:   m = 2'b00;
            ST_OVER:   m = 2'b01;
            ST_ACK1:   m = 2'b01;
            ST_WAIT_R: m = 2'b01;
            ST_READY:  m = 2'b10;
            ST_ACK2:   m = 2'b10;
            ST_WAIT_P: m = 2'b10;
            default:   m = 2'b00;
        endcase
        return m;
    endfunction

    // ---------------------------------------------------------------- button
    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic            deb_dly_q;
    logic            press_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_center_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count samples that differ from the accepted level; a sample
    // equal to the accepted level restarts the count.
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == deb_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            deb_d    = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Debounced level, its delayed copy and the registered rising-edge press event.
    // The accepted level starts at 0, so a button held through reset release
    // still has to pass the full debounce before it counts as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q     <= 1'b0;
            db_cnt_q  <= '0;
            deb_dly_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            db_cnt_q  <= db_cnt_d;
            deb_dly_q <= deb_q;
            press_q   <= deb_q & ~deb_dly_q;
        end
    end

    // ------------------------------------------------------------------- FSM
    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               ack_q, ack_d;
    logic [1:0]         disp_q, disp_d;

    // Next-state, scoring, timeout and output decode.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        best_d  = best_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_PLAY: begin
                // A hit in the same cycle as finish_i is still counted.
                if (hit_i) begin
                    score_d = sat_inc(score_q);
                end else begin
                    score_d = score_q;
                end
                if (finish_i) begin
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                // Score is frozen in OVER, so this only changes best on entry.
                if (score_q > best_q) begin
                    best_d = score_q;
                end else begin
                    best_d = best_q;
                end
                if (press_q) begin
                    state_d = ST_ACK1;
                end else begin
                    state_d = ST_OVER;
                end
            end
            ST_ACK1: begin
                tmo_d   = TMO_LOAD;
                state_d = ST_WAIT_R;
            end
            ST_WAIT_R: begin
                // Presses are never looked at here, so a timeout always wins.
                if (reset_i) begin
                    score_d = '0;
                    state_d = ST_READY;
                end else if (tmo_q <= TMO_W'(1)) begin
                    err_d   = 1'b1;
                    state_d = ST_OVER;
                end else begin
                    tmo_d   = tmo_q - TMO_W'(1);
                end
            end
            ST_READY: begin
                if (press_q) begin
                    state_d = ST_ACK2;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_ACK2: begin
                tmo_d   = TMO_LOAD;
                state_d = ST_WAIT_P;
            end
            ST_WAIT_P: begin
                if (!reset_i && !finish_i) begin
                    state_d = ST_PLAY;
                end else if (tmo_q <= TMO_W'(1)) begin
                    err_d   = 1'b1;
                    score_d = '0;
                    state_d = ST_READY;
                end else begin
                    tmo_d   = tmo_q - TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase
        // Outputs are registered from the next state so they line up with it.
        ack_d  = (state_d == ST_ACK1) || (state_d == ST_ACK2);
        disp_d = disp_of(state_d);
    end

    // State, score, timeout and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PLAY;
            score_q <= '0;
            best_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            ack_q   <= 1'b0;
            disp_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            best_q  <= best_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            ack_q   <= ack_d;
            disp_q  <= disp_d;
        end
    end

    assign ack_o       = ack_q;
    assign score_o     = score_q;
    assign best_o      = best_q;
    assign disp_mode_o = disp_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_round_ack_responder.sv
// -----------------------------------------------------------------------------
// tb_round_ack_responder
// Directed bench for round_ack_responder: reset, scoring, full handshake,
// held button, bounce rejection, timeout, saturation and mid-run reset.
// -----------------------------------------------------------------------------
module tb_round_ack_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       finish_i;
    logic       reset_i;
    logic       btn_center_i;
    logic       hit_i;
    logic       ack_o;
    logic [7:0] score_o;
    logic [7:0] best_o;
    logic [1:0] disp_mode_o;
    logic       err_o;

    int checks   = 0;
    int failures = 0;
    int acks;

    round_ack_responder #(
        .DEBOUNCE_CYCLES(4),
        .SCORE_W        (8),
        .ACK_TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .finish_i    (finish_i),
        .reset_i     (reset_i),
        .btn_center_i(btn_center_i),
        .hit_i       (hit_i),
        .ack_o       (ack_o),
        .score_o     (score_o),
        .best_o      (best_o),
        .disp_mode_o (disp_mode_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        finish_i     = 1'b0;
        reset_i      = 1'b0;
        btn_center_i = 1'b1;   // T1: button held through reset
        hit_i        = 1'b0;

        // ---- T1 reset
        step(3);
        check("rst_ack",   32'(ack_o), 32'd0);
        check("rst_score", 32'(score_o), 32'd0);
        check("rst_best",  32'(best_o), 32'd0);
        check("rst_disp",  32'(disp_mode_o), 32'd0);
        check("rst_err",   32'(err_o), 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            check("t1_press", 32'(dut.press_q), (k == 7) ? 32'd1 : 32'd0);
            check("t1_ack",   32'(ack_o), 32'd0);
        end
        check("t1_disp", 32'(disp_mode_o), 32'd0);
        btn_center_i = 1'b0;
        step(10);

        // ---- T2 score
        for (int i = 0; i < 5; i++) begin
            hit_i = 1'b1;
            step(1);
        end
        check("t2_score5", 32'(score_o), 32'd5);
        hit_i    = 1'b1;
        finish_i = 1'b1;
        step(1);
        hit_i = 1'b0;
        check("t2_score6", 32'(score_o), 32'd6);
        check("t2_disp_over", 32'(disp_mode_o), 32'd1);
        check("t2_best_entry", 32'(best_o), 32'd0);
        step(1);
        check("t2_best6", 32'(best_o), 32'd6);
        hit_i = 1'b1;
        step(1);
        hit_i = 1'b0;
        check("t2_hit_ignored", 32'(score_o), 32'd6);

        // ---- T3 full handshake
        btn_center_i = 1'b1;
        step(7);
        check("t3_ack1_early", 32'(ack_o), 32'd0);
        step(1);
        check("t3_ack1", 32'(ack_o), 32'd1);
        step(1);
        check("t3_ack1_end", 32'(ack_o), 32'd0);
        check("t3_wait_disp", 32'(disp_mode_o), 32'd1);
        reset_i  = 1'b1;
        finish_i = 1'b0;
        step(1);
        check("t3_ready_disp", 32'(disp_mode_o), 32'd2);
        check("t3_ready_score", 32'(score_o), 32'd0);
        check("t3_ready_best", 32'(best_o), 32'd6);
        btn_center_i = 1'b0;
        step(10);
        check("t3_release_ack", 32'(ack_o), 32'd0);
        btn_center_i = 1'b1;
        step(7);
        check("t3_ack2_early", 32'(ack_o), 32'd0);
        step(1);
        check("t3_ack2", 32'(ack_o), 32'd1);
        step(1);
        check("t3_ack2_end", 32'(ack_o), 32'd0);
        check("t3_waitp_disp", 32'(disp_mode_o), 32'd2);
        reset_i = 1'b0;
        step(1);
        check("t3_play_disp", 32'(disp_mode_o), 32'd0);
        check("t3_err", 32'(err_o), 32'd0);
        btn_center_i = 1'b0;
        step(10);

        // ---- T6 timeout
        hit_i = 1'b1;
        step(2);
        hit_i    = 1'b0;
        finish_i = 1'b1;
        step(1);
        check("t6_score", 32'(score_o), 32'd2);
        check("t6_disp_over", 32'(disp_mode_o), 32'd1);
        step(1);
        check("t6_best_kept", 32'(best_o), 32'd6);
        btn_center_i = 1'b1;
        step(8);
        check("t6_ack", 32'(ack_o), 32'd1);
        step(1);
        check("t6_ack_end", 32'(ack_o), 32'd0);
        step(15);
        check("t6_err_before", 32'(err_o), 32'd0);
        step(1);
        check("t6_err_set", 32'(err_o), 32'd1);
        check("t6_back_over", 32'(disp_mode_o), 32'd1);
        btn_center_i = 1'b0;
        step(10);
        check("t6_no_ack", 32'(ack_o), 32'd0);

        // ---- T4 held button with a timer model, re-press after timeout acks
        btn_center_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (ack_o) begin
                acks++;
                reset_i  = 1'b1;
                finish_i = 1'b0;
            end
        end
        check("t4_one_ack", 32'(acks), 32'd1);
        check("t4_ready", 32'(disp_mode_o), 32'd2);
        check("t4_err_sticky", 32'(err_o), 32'd1);

        // ---- T5 bounce in READY
        btn_center_i = 1'b0;
        step(10);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            btn_center_i = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            step(1);
            if (ack_o) acks++;
        end
        check("t5_bounce_no_ack", 32'(acks), 32'd0);
        btn_center_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (ack_o) begin
                acks++;
                reset_i  = 1'b0;
                finish_i = 1'b0;
            end
        end
        check("t5_stable_ack", 32'(acks), 32'd1);
        check("t5_play", 32'(disp_mode_o), 32'd0);

        // ---- saturation
        hit_i = 1'b1;
        step(256);
        hit_i = 1'b0;
        check("sat_score", 32'(score_o), 32'd255);
        check("sat_best_hold", 32'(best_o), 32'd6);
        finish_i = 1'b1;
        step(2);
        check("sat_best", 32'(best_o), 32'd255);
        check("sat_disp", 32'(disp_mode_o), 32'd1);

        // ---- asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_score", 32'(score_o), 32'd0);
        check("mid_rst_best",  32'(best_o), 32'd0);
        check("mid_rst_disp",  32'(disp_mode_o), 32'd0);
        check("mid_rst_err",   32'(err_o), 32'd0);
        check("mid_rst_ack",   32'(ack_o), 32'd0);
        finish_i = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        check("post_rst_disp", 32'(disp_mode_o), 32'd0);
        check("post_rst_err",  32'(err_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
